div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Sequential 32-bit integer divider: the inverse companion to the MULT32 multiplier in the execute stage's HI/LO datapath.
- Takes dividend OP1 and divisor OP2 and returns quotient on LO and remainder on HI, following the MIPS DIV/DIVU convention.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock, with a START/BUSY/DONE handshake so the pipeline can stall on it.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = DIV (two's complement), 0 = DIVU; latched with START.
- OP1  input  WIDTH  dividend; latched with START.
- OP2  input  WIDTH  divisor; latched with START.
- HI  output  WIDTH  remainder; registered.
- LO  output  WIDTH  quotient; registered.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when HI/LO are updated.

Behaviour:
- Reset (async, any state): state=IDLE; HI=0, LO=0, BUSY=0, DONE=0; counter and internal registers cleared. An operation in flight is abandoned and HI/LO are not updated.
- States:
  - IDLE: START=1 at edge E0 latches SIGNED, OP1 and OP2 and goes to CALC.
  - CALC: counter runs 0..WIDTH-1, one iteration per edge.
  - FIN: sign-correct the result and write HI/LO.
  - FIN returns to IDLE.
- Timing:
  - BUSY=1 from after E0 until after E33.
  - Iterations occur at edges E1..E32.
  - At E33 HI/LO are written, DONE=1 for exactly one cycle, BUSY=0, and the state returns to IDLE.
  - Fixed latency: DONE is visible in the cycle following E33, i.e. 33 cycles after START is sampled. This holds for all operands, including divide-by-zero.
- START while BUSY=1 is ignored, and the latched operands are unaffected.
- START in the DONE cycle is accepted (state is IDLE); back-to-back throughput is 1 op per 34 cycles.
- HI/LO hold their last result until the next FIN; OP1/OP2 changes after E0 have no effect.
- Magnitude path:
  - If SIGNED=1, take absolute values; |0x80000000| = 0x80000000 as an unsigned magnitude.
  - Restoring step: rem = {rem[W-2:0], dvd[W-1]}, dvd <<= 1; if rem >= dvs, then rem -= dvs and q bit = 1. The compare uses a WIDTH+1-bit subtract.
- Sign correction (SIGNED=1 only):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - This gives quotient truncation toward zero.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the algorithm and needs no special case.
- Divide by zero (OP2==0): LO=0xFFFFFFFF, HI=OP1 as latched, for both SIGNED values. Implement it as an explicit override in FIN; latency is unchanged.

Decomposition:
- Shared package (cpu_pkg) holds:
  - DATA_W=32.
  - The divider state encoding: IDLE=2'b00, CALC=2'b01, FIN=2'b10.
  - The DIV_LATENCY=33 constant, used by the hazard/stall unit.
- One natural sub-module: div_step, a purely combinational single iteration. It takes rem_in, dvd_msb and dvs, and returns rem_out and q_bit.
- The FSM, counter, sign handling and output registers live in div32_seq.

Test Plan:
- Unsigned 100/7, SIGNED=0, START pulsed for one cycle -> BUSY for 33 cycles, then a DONE pulse with LO=14, HI=2. DONE is high for exactly 1 cycle.
- Signed -7/2 (OP1=0xFFFFFFF9, OP2=2, SIGNED=1) -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also cover 7/-2 -> LO=-3, HI=1.
- Edge operands:
  - 0x80000000/0xFFFFFFFF signed -> LO=0x80000000, HI=0.
  - 0xFFFFFFFF/1 unsigned -> LO=0xFFFFFFFF, HI=0.
  - 0/5 -> LO=0, HI=0.
- Divide by zero: OP1=123, OP2=0, both SIGNED=0 and SIGNED=1 -> LO=0xFFFFFFFF, HI=123, still 33-cycle latency.
- Handshake:
  - START 10/3; at cycle 5 re-pulse START with 50/5 and change OP1 -> first result LO=3, HI=1 only, and no second DONE.
  - Then START in the DONE cycle with 50/5 -> LO=10, HI=0 after 33 more cycles.
- Reset mid-op: START 100/7, assert RST asynchronously (off clock edge) at cycle 10 -> BUSY, DONE, HI and LO drop to 0 immediately, no DONE follows, and the next START computes correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: datapath width, divider states and latency.
package cpu_pkg;

   localparam int unsigned DATA_W      = 32;
   // Cycles from START being sampled until DONE is visible; used by the stall unit.
   localparam int unsigned DIV_LATENCY = 33;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider (purely combinational).
module div_step
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] diff;

   // Shift in the next dividend bit, trial-subtract with one guard bit, restore on borrow.
   always_comb begin
      trial   = {rem_in, dvd_msb};
      diff    = {1'b0, trial} - {2'b00, dvs};
      q_bit   = ~diff[WIDTH+1];
      rem_out = q_bit ? WIDTH'(diff) : WIDTH'(trial);
   end

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider with fixed 33-cycle latency (MIPS DIV/DIVU semantics).
// LO = quotient, HI = remainder; divide-by-zero yields LO = all ones, HI = dividend.
module div32_seq
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] OP1,
   input  logic [WIDTH-1:0] OP2,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             BUSY,
   output logic             DONE
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;     // dividend magnitude, shifts into the quotient
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] op1_q;   // raw dividend, returned on HI for divide-by-zero
   logic             neg_q;
   logic             neg_r;
   logic             dvz;

   logic [WIDTH-1:0] rem_nxt;
   logic             q_bit;

   // Unsigned magnitude; the most negative value maps onto itself as an unsigned number.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? (WIDTH'(0) - x) : x;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[WIDTH-1]),
      .dvs     (dvs),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   // Control FSM, iteration datapath and registered results.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         op1_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dvz   <= 1'b0;
         HI    <= '0;
         LO    <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  state <= CALC;
                  BUSY  <= 1'b1;
                  cnt   <= '0;
                  rem   <= '0;
                  dvd   <= mag(OP1, SIGNED);
                  dvs   <= mag(OP2, SIGNED);
                  op1_q <= OP1;
                  neg_q <= SIGNED & (OP1[WIDTH-1] ^ OP2[WIDTH-1]);
                  neg_r <= SIGNED & OP1[WIDTH-1];
                  dvz   <= (OP2 == '0);
               end
            end
            CALC: begin
               rem <= rem_nxt;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               if (dvz) begin
                  LO <= '1;
                  HI <= op1_q;
               end else begin
                  LO <= neg_q ? (WIDTH'(0) - dvd) : dvd;
                  HI <= neg_r ? (WIDTH'(0) - rem) : rem;
               end
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: directed corner cases plus randomized operands.
module tb_div32_seq;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          e0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_done = 1'b0;

   div32_seq dut (
      .CLK    (clk),
      .RST    (rst),
      .START  (start),
      .SIGNED (sgn),
      .OP1    (op1),
      .OP2    (op2),
      .HI     (hi),
      .LO     (lo),
      .BUSY   (busy),
      .DONE   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: truncating division with the dividend's remainder sign, via wide integers.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] rhi, output logic [31:0] rlo);
      longint sa, sb_, q, r;
      if (b == 32'd0) begin
         rlo = 32'hFFFF_FFFF;
         rhi = a;
      end else if (s) begin
         sa  = longint'($signed(a));
         sb_ = longint'($signed(b));
         q   = sa / sb_;
         r   = sa % sb_;
         rlo = q[31:0];
         rhi = r[31:0];
      end else begin
         rlo = a / b;
         rhi = a % b;
      end
   endtask

   // Present an operation for one edge; must be entered while the clock is low.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit push);
      exp_t e;
      op1   = a;
      op2   = b;
      sgn   = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.hi = ehi;
         e.lo = elo;
         e.e0 = cyc;
         sb.push_back(e);
      end
      chk("busy_after_start", 32'(busy), 32'd1);
      op1 = $urandom;
      op2 = $urandom;
      sgn = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: DONE not seen within 60 cycles, expected within 33", name);
      end
   endtask

   task automatic run_rand(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] ehi, elo;
      ref_div(a, b, s, ehi, elo);
      issue(a, b, s, ehi, elo, 1'b1);
      wait_done("random_op");
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      op1   = '0;
      op2   = '0;

      // Monitor: pops the scoreboard on every DONE and checks result and latency.
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (done) begin
                  chk("done_single_cycle", 32'(prev_done), 32'd0);
                  chk("busy_low_in_done", 32'(busy), 32'd0);
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_done: got DONE with LO=%h HI=%h, expected no DONE", lo, hi);
                  end else begin
                     mon_e = sb.pop_front();
                     chk("lo", lo, mon_e.lo);
                     chk("hi", hi, mon_e.hi);
                     chk("latency", 32'(cyc - mon_e.e0), 32'd33);
                  end
               end
               prev_done = done;
            end else begin
               prev_done = 1'b0;
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed cases; each new op starts in the previous DONE cycle.
      issue(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b1);                         wait_done("u100_7");
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);     wait_done("s_m7_2");
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b1);             wait_done("s_7_m2");
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b1);     wait_done("s_ovf");
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);             wait_done("u_max_1");
      issue(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b1);                             wait_done("u_0_5");
      issue(32'd123, 32'd0, 1'b0, 32'd123, 32'hFFFF_FFFF, 1'b1);                 wait_done("u_dvz");
      issue(32'd123, 32'd0, 1'b1, 32'd123, 32'hFFFF_FFFF, 1'b1);                 wait_done("s_dvz");

      // START while busy is ignored; operand changes after acceptance have no effect.
      issue(32'd10, 32'd3, 1'b0, 32'd1, 32'd3, 1'b1);
      repeat (4) @(negedge clk);
      op1   = 32'd50;
      op2   = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op1   = 32'd999;
      wait_done("busy_ignore");
      issue(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 1'b1);                           wait_done("start_in_done");
      issue(32'd17, 32'd5, 1'b0, 32'd2, 32'd3, 1'b1);                            wait_done("pre_reset");

      // Asynchronous reset mid-operation abandons it and clears the outputs at once.
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midreset_hi", hi, 32'd0);
      chk("midreset_lo", lo, 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_reset_idle_busy", 32'(busy), 32'd0);
      issue(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b1);                          wait_done("after_reset");

      // Randomized operands biased toward small, zero and extreme divisors.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a, b;
         int unsigned mode;
         mode = $urandom_range(0, 9);
         a    = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case (mode)
            0:       b = 32'd0;
            1, 2, 3: b = 32'($urandom_range(1, 15));
            4:       b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            5:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         run_rand(a, b, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
